// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive blocks: FSM states, parity modes, period floor.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int unsigned MIN_PERIOD = 4;

  // Mode 3 is treated as no parity, same as PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high serial line plus a registered falling-edge detector.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic synced_o,
  output logic start_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign synced_o = sync2_q;
  assign start_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver with runtime bit period, optional parity, framing check and break recovery.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PERIOD_W  = 20
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [PERIOD_W-1:0]  i_Period,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_UART_RX,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Valid,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  logic synced, start_pulse;

  uart_rx_sync u_sync (
    .clk_i    (i_Clk),
    .rst_i    (i_Rst),
    .rx_i     (i_UART_RX),
    .synced_o (synced),
    .start_o  (start_pulse)
  );

  rx_state_e              state_q, state_d;
  logic [PERIOD_W-1:0]    cnt_q, cnt_d;
  logic [PERIOD_W-1:0]    period_q, period_d;
  logic [PERIOD_W-1:0]    half_q, half_d;
  logic [1:0]             mode_q, mode_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_run_q, par_run_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= '0;
      half_q    <= '0;
      mode_q    <= PAR_NONE;
      idx_q     <= '0;
      shift_q   <= '0;
      par_run_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      half_q    <= half_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_run_q <= par_run_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    half_d    = half_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_run_d = par_run_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    unique case (state_q)
      StIdle: begin
        if (start_pulse) begin
          period_d  = i_Period;
          half_d    = i_Period >> 1;
          mode_d    = i_Parity_Mode;
          shift_d   = '0;
          idx_d     = '0;
          par_run_d = 1'b0;
          if (i_Period >= PERIOD_W'(MIN_PERIOD)) begin
            state_d = StStart;
            cnt_d   = PERIOD_W'(1);
          end
        end
      end
      StStart: begin
        if (cnt_q == half_q) begin
          cnt_d   = PERIOD_W'(1);
          // A high line at mid-start means the falling edge was a glitch.
          state_d = synced ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      StData: begin
        if (cnt_q == period_q) begin
          // LSB arrives first, so shifting right leaves it at bit 0 after the last bit.
          shift_d = {synced, shift_q[DATA_BITS-1:1]};
          cnt_d   = PERIOD_W'(1);
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            state_d = parity_enabled(mode_q) ? StParity : StStop;
          end
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      StParity: begin
        if (cnt_q == period_q) begin
          par_run_d = ((^shift_q) ^ synced) != (mode_q == PAR_ODD);
          cnt_d     = PERIOD_W'(1);
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      StStop: begin
        if (cnt_q == period_q) begin
          data_d  = shift_q;
          ferr_d  = ~synced;
          perr_d  = parity_enabled(mode_q) ? par_run_q : 1'b0;
          valid_d = 1'b1;
          cnt_d   = PERIOD_W'(1);
          state_d = synced ? StIdle : StWaitIdle;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      StWaitIdle: begin
        if (synced) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_Data       = data_q;
  assign o_Valid      = valid_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Busy       = (state_q != StIdle);

endmodule
